// File: rtl/alu_pkg.sv
// Shared definitions for the issue/writeback stage and the ALU behind it:
// opcode values, instruction field positions, the stage state encoding and
// the value written back when a divide by zero is screened out.
package alu_pkg;

    // Opcodes; the ALU decodes exactly the same values.
    localparam logic [4:0] OP_NOP = 5'h00;
    localparam logic [4:0] OP_ADD = 5'h01;
    localparam logic [4:0] OP_SUB = 5'h02;
    localparam logic [4:0] OP_AND = 5'h03;
    localparam logic [4:0] OP_OR  = 5'h04;
    localparam logic [4:0] OP_XOR = 5'h05;
    localparam logic [4:0] OP_SHL = 5'h06;
    localparam logic [4:0] OP_MUL = 5'h07;
    localparam logic [4:0] OP_DIV = 5'h08;
    localparam logic [4:0] OP_ROL = 5'h09;
    localparam logic [4:0] OP_MAX = 5'h09;

    // Instruction word layout: [31:27] op, [26:24] rd, [23:21] rs1,
    // [20:18] rs2, [17] imm_en, [16] reserved, [15:0] imm.
    localparam int F_OP_LSB    = 27;
    localparam int F_RD_LSB    = 24;
    localparam int F_RS1_LSB   = 21;
    localparam int F_RS2_LSB   = 18;
    localparam int F_IMMEN_BIT = 17;
    localparam int F_RSVD_BIT  = 16;
    localparam int F_IMM_LSB   = 0;
    localparam int IMM_W       = 16;

    // Stage states, in the order an instruction walks through them.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXEC,
        ST_WAIT,
        ST_WB,
        ST_WB_HI
    } state_t;

    // Result forced into rd when a DIV is screened for a zero divisor.
    localparam logic [31:0] DIV0_RESULT = 32'hFFFFFFFF;

endpackage

// File: rtl/alu_regfile.sv
// Register file for the issue stage: two combinational operand read ports,
// one combinational debug read port and one synchronous write port.
// Register 0 is hardwired to zero; writes to it are silently dropped.
module alu_regfile #(
    parameter int  NREGS = 8,
    parameter int  DW    = 32,
    localparam int RW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_we,
    input  logic [RW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [RW-1:0] i_raddr1,
    input  logic [RW-1:0] i_raddr2,
    input  logic [RW-1:0] i_dbgAddr,
    output logic [DW-1:0] o_rdata1,
    output logic [DW-1:0] o_rdata2,
    output logic [DW-1:0] o_dbgData
);

    logic [DW-1:0] r_mem [NREGS];

    // Storage: reset clears every entry, otherwise one write per cycle,
    // skipping register 0 so that it can never hold anything but zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && (i_waddr != '0)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read ports force zero for register 0 rather than trusting storage.
    assign o_rdata1  = (i_raddr1  == '0) ? '0 : r_mem[i_raddr1];
    assign o_rdata2  = (i_raddr2  == '0) ? '0 : r_mem[i_raddr2];
    assign o_dbgData = (i_dbgAddr == '0) ? '0 : r_mem[i_dbgAddr];

endmodule

// File: rtl/alu_issue_wb.sv
// Issue and writeback stage wrapped around a registered ALU. One instruction
// is in flight at a time: it is decoded, screened for illegal opcodes and
// zero divisors, issued on registered alu_* outputs, and its result (both
// halves for MUL) is written back into the local register file.
module alu_issue_wb
    import alu_pkg::*;
#(
    parameter int  NREGS = 8,
    parameter int  DW    = 32,
    localparam int RW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [31:0]     in_instr,
    output logic            in_ready,
    output logic [DW-1:0]   alu_a,
    output logic [DW-1:0]   alu_b,
    output logic [4:0]      alu_op,
    input  logic [DW-1:0]   alu_out,
    input  logic [2*DW-1:0] alu_out2,
    output logic            wb_valid,
    output logic [RW-1:0]   wb_addr,
    output logic [DW-1:0]   wb_data,
    output logic            err_illegal,
    output logic            err_div0,
    input  logic [RW-1:0]   dbg_addr,
    output logic [DW-1:0]   dbg_data
);

    state_t r_state;
    state_t w_nextState;

    logic [4:0]       w_op;
    logic [RW-1:0]    w_rd;
    logic [RW-1:0]    w_rs1;
    logic [RW-1:0]    w_rs2;
    logic             w_immEn;
    logic [IMM_W-1:0] w_imm;
    logic             w_unusedReserved;

    logic [DW-1:0] w_rs1Data;
    logic [DW-1:0] w_rs2Data;
    logic [DW-1:0] w_immExt;
    logic [DW-1:0] w_opB;

    logic w_xfer;
    logic w_illegal;
    logic w_isNop;
    logic w_div0;
    logic w_accept;
    logic w_issue;

    logic [RW-1:0] r_rd;
    logic [4:0]    r_op;
    logic          r_force;
    logic [DW-1:0] r_hiHalf;

    logic [DW-1:0] r_aluA;
    logic [DW-1:0] r_aluB;
    logic [4:0]    r_aluOp;

    logic          w_we;
    logic [RW-1:0] w_waddr;
    logic [DW-1:0] w_wdata;
    logic [RW-1:0] r_wbAddrHeld;
    logic [DW-1:0] r_wbDataHeld;

    logic r_errIllegal;
    logic r_errDiv0;

    // Field extraction straight off the incoming word; only meaningful on a
    // transfer, which is the only time it is consumed.
    assign w_op             = in_instr[F_OP_LSB +: 5];
    assign w_rd             = in_instr[F_RD_LSB +: RW];
    assign w_rs1            = in_instr[F_RS1_LSB +: RW];
    assign w_rs2            = in_instr[F_RS2_LSB +: RW];
    assign w_immEn          = in_instr[F_IMMEN_BIT];
    assign w_imm            = in_instr[F_IMM_LSB +: IMM_W];
    assign w_unusedReserved = in_instr[F_RSVD_BIT];

    assign w_immExt = {{(DW-IMM_W){w_imm[IMM_W-1]}}, w_imm};
    assign w_opB    = w_immEn ? w_immExt : w_rs2Data;

    assign in_ready = (r_state == ST_IDLE);
    assign w_xfer   = in_valid && in_ready;

    // Screening: illegal and NOP never leave IDLE; a zero divisor skips the
    // ALU entirely and goes straight to writeback with the forced result.
    assign w_illegal = (w_op > OP_MAX);
    assign w_isNop   = (w_op == OP_NOP);
    assign w_div0    = (w_op == OP_DIV) && (w_opB == '0);
    assign w_accept  = w_xfer && !w_illegal && !w_isNop;
    assign w_issue   = w_accept && !w_div0;

    alu_regfile #(
        .NREGS (NREGS),
        .DW    (DW)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .i_we      (w_we),
        .i_waddr   (w_waddr),
        .i_wdata   (w_wdata),
        .i_raddr1  (w_rs1),
        .i_raddr2  (w_rs2),
        .i_dbgAddr (dbg_addr),
        .o_rdata1  (w_rs1Data),
        .o_rdata2  (w_rs2Data),
        .o_dbgData (dbg_data)
    );

    // State register; reset drops any instruction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: fixed walk EXEC -> WAIT -> WB, with an extra WB_HI
    // cycle only for a real MUL (never for a forced divide-by-zero result).
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_nextState = w_div0 ? ST_WB : ST_EXEC;
                end
            end
            ST_EXEC:  w_nextState = ST_WAIT;
            ST_WAIT:  w_nextState = ST_WB;
            ST_WB: begin
                if ((r_op == OP_MUL) && !r_force) begin
                    w_nextState = ST_WB_HI;
                end else begin
                    w_nextState = ST_IDLE;
                end
            end
            ST_WB_HI: w_nextState = ST_IDLE;
            default:  w_nextState = ST_IDLE;
        endcase
    end

    // Instruction latch and ALU drive: operands load only on a genuine
    // issue, and the opcode drops back to NOP once the ALU has captured it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd    <= '0;
            r_op    <= OP_NOP;
            r_force <= 1'b0;
            r_aluA  <= '0;
            r_aluB  <= '0;
            r_aluOp <= OP_NOP;
        end else begin
            if (w_accept) begin
                r_rd    <= w_rd;
                r_op    <= w_op;
                r_force <= w_div0;
            end
            if (w_issue) begin
                r_aluA  <= w_rs1Data;
                r_aluB  <= w_opB;
                r_aluOp <= w_op;
            end else if (r_state == ST_WAIT) begin
                r_aluOp <= OP_NOP;
            end
        end
    end

    assign alu_a  = r_aluA;
    assign alu_b  = r_aluB;
    assign alu_op = r_aluOp;

    // Writeback source select. The MUL high half comes from a copy taken
    // during WB, because the ALU has already been handed a NOP by then and
    // its outputs are not guaranteed to survive into WB_HI.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_rd;
        w_wdata = alu_out;
        case (r_state)
            ST_WB: begin
                w_we = 1'b1;
                if (r_force) begin
                    w_wdata = DW'(DIV0_RESULT);
                end else if (r_op == OP_MUL) begin
                    w_wdata = alu_out2[DW-1:0];
                end else begin
                    w_wdata = alu_out;
                end
            end
            ST_WB_HI: begin
                w_we    = 1'b1;
                w_waddr = r_rd + RW'(1);
                w_wdata = r_hiHalf;
            end
            default: begin
                w_we = 1'b0;
            end
        endcase
    end

    // Remember the last write so wb_addr/wb_data hold between pulses, and
    // capture the MUL high half while the ALU result is still valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wbAddrHeld <= '0;
            r_wbDataHeld <= '0;
            r_hiHalf     <= '0;
        end else begin
            if (w_we) begin
                r_wbAddrHeld <= w_waddr;
                r_wbDataHeld <= w_wdata;
            end
            if (r_state == ST_WB) begin
                r_hiHalf <= alu_out2[2*DW-1:DW];
            end
        end
    end

    assign wb_valid = w_we;
    assign wb_addr  = w_we ? w_waddr : r_wbAddrHeld;
    assign wb_data  = w_we ? w_wdata : r_wbDataHeld;

    // Error pulses: one cycle, in the cycle right after the offending transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_errIllegal <= 1'b0;
            r_errDiv0    <= 1'b0;
        end else begin
            r_errIllegal <= w_xfer && w_illegal;
            r_errDiv0    <= w_xfer && w_div0;
        end
    end

    assign err_illegal = r_errIllegal;
    assign err_div0    = r_errDiv0;

endmodule

// File: tb/tb_alu_issue_wb.sv
// Bench for alu_issue_wb: a behavioural registered ALU, a register-level
// reference model of the architectural state, a directed vector table, a
// reset-in-flight sequence and a randomized instruction stream.
module tb_alu_issue_wb;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        in_ready;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  alu_op;
    logic [31:0] alu_out;
    logic [63:0] alu_out2;
    logic        wb_valid;
    logic [2:0]  wb_addr;
    logic [31:0] wb_data;
    logic        err_illegal;
    logic        err_div0;
    logic [2:0]  dbg_addr;
    logic [31:0] dbg_data;

    int total = 0;
    int bad   = 0;
    int divZeroIssued = 0;

    logic [31:0] mdl [8];
    logic [63:0] aluReg;

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  dbgAddr;
        logic [31:0] expDbg;
        int          expLat;
    } vec_t;

    vec_t vecs[$];

    alu_issue_wb #(.NREGS(8), .DW(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_instr    (in_instr),
        .in_ready    (in_ready),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_out     (alu_out),
        .alu_out2    (alu_out2),
        .wb_valid    (wb_valid),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .err_illegal (err_illegal),
        .err_div0    (err_div0),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    always #5 clk = ~clk;

    // Reference ALU semantics: signed operands, shift/rotate by B[4:0],
    // full 64-bit signed product for MUL.
    function automatic logic [63:0] aluRef(input logic [4:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        logic [31:0] r;
        longint      p;
        int          sh;
        r  = '0;
        sh = int'(b[4:0]);
        case (op)
            OP_ADD: r = a + b;
            OP_SUB: r = a - b;
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            OP_SHL: r = a << sh;
            OP_MUL: begin
                p = longint'($signed(a)) * longint'($signed(b));
                return p;
            end
            OP_DIV: begin
                if (b == 0) r = '0;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = a;
                else r = $signed(a) / $signed(b);
            end
            OP_ROL: r = (a << sh) | (a >> (32 - sh));
            default: r = '0;
        endcase
        return {32'h0, r};
    endfunction

    // The external ALU: captures operands on every rising edge.
    always @(posedge clk) aluReg <= aluRef(alu_op, alu_a, alu_b);
    assign alu_out  = aluReg[31:0];
    assign alu_out2 = aluReg;

    // Watch for a zero-divisor DIV ever reaching the ALU.
    always @(negedge clk) begin
        if (!rst && alu_op == OP_DIV && alu_b == 32'h0) divZeroIssued++;
    end

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs1, input logic [2:0] rs2,
                                       input logic ie, input logic [15:0] imm);
        return {op, rd, rs1, rs2, ie, 1'b0, imm};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, wanted %0h", name, act, exp);
        end
    endtask

    // Present one instruction and complete the transfer edge.
    task automatic applyStimulus(input logic [31:0] instr);
        int guard = 0;
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) checkOutput("readyTimeout", 0, 1);
        in_valid = 1'b1;
        in_instr = instr;
        @(posedge clk);
    endtask

    // Issue one instruction, observe six cycles and compare every pulse and
    // the ready latency against what the architectural model predicts.
    task automatic runInstr(input logic [31:0] instr, input string tag);
        logic [4:0]  op;
        logic [2:0]  rd;
        logic [2:0]  rdHi;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] res;
        int expLat, expIll, expDiv, obsLat, illCnt, illK, divCnt, divK;
        int expK[$];
        logic [2:0]  expA[$];
        logic [31:0] expD[$];
        int obsK[$];
        logic [2:0]  obsA[$];
        logic [31:0] obsD[$];

        op   = instr[31:27];
        rd   = instr[26:24];
        rdHi = rd + 3'd1;
        a    = mdl[instr[23:21]];
        b    = instr[17] ? {{16{instr[15]}}, instr[15:0]} : mdl[instr[20:18]];
        expIll = 0;
        expDiv = 0;
        if (op > 5'h09) begin
            expIll = 1;
            expLat = 1;
        end else if (op == OP_NOP) begin
            expLat = 1;
        end else if (op == OP_DIV && b == 0) begin
            expDiv = 1;
            expLat = 2;
            expK.push_back(1); expA.push_back(rd); expD.push_back(32'hFFFFFFFF);
        end else begin
            res = aluRef(op, a, b);
            expK.push_back(3); expA.push_back(rd); expD.push_back(res[31:0]);
            if (op == OP_MUL) begin
                expK.push_back(4); expA.push_back(rdHi); expD.push_back(res[63:32]);
                expLat = 5;
            end else begin
                expLat = 4;
            end
        end
        foreach (expA[i]) if (expA[i] != 0) mdl[expA[i]] = expD[i];

        applyStimulus(instr);
        obsLat = 0; illCnt = 0; illK = 0; divCnt = 0; divK = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (wb_valid) begin
                obsK.push_back(k); obsA.push_back(wb_addr); obsD.push_back(wb_data);
            end
            if (err_illegal) begin illCnt++; illK = k; end
            if (err_div0)    begin divCnt++; divK = k; end
            if (obsLat == 0 && in_ready) obsLat = k;
            if (!in_ready) begin
                in_valid = 1'b1;
                in_instr = $urandom;
            end else begin
                in_valid = 1'b0;
            end
        end

        checkOutput({tag, " readyLatency"}, obsLat, expLat);
        checkOutput({tag, " wbCount"}, obsK.size(), expK.size());
        for (int i = 0; i < expK.size() && i < obsK.size(); i++) begin
            checkOutput({tag, " wbCycle"}, obsK[i], expK[i]);
            checkOutput({tag, " wbAddr"}, obsA[i], expA[i]);
            checkOutput({tag, " wbData"}, obsD[i], expD[i]);
        end
        checkOutput({tag, " errIllegalCount"}, illCnt, expIll);
        if (expIll == 1) checkOutput({tag, " errIllegalCycle"}, illK, 1);
        checkOutput({tag, " errDiv0Count"}, divCnt, expDiv);
        if (expDiv == 1) checkOutput({tag, " errDiv0Cycle"}, divK, 1);
    endtask

    task automatic checkDbg(input logic [2:0] addr, input logic [31:0] exp, input string tag);
        dbg_addr = addr;
        #1;
        checkOutput({tag, " dbg"}, dbg_data, exp);
    endtask

    initial begin
        logic [31:0] rInstr;
        logic [4:0]  rOp;
        int          wbSeen;

        rst      = 1'b1;
        in_valid = 1'b0;
        in_instr = '0;
        dbg_addr = '0;
        foreach (mdl[i]) mdl[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state.
        checkOutput("reset in_ready", in_ready, 1);
        checkOutput("reset alu_op", alu_op, 0);
        checkOutput("reset alu_a", alu_a, 0);
        checkOutput("reset alu_b", alu_b, 0);
        checkOutput("reset wb_valid", wb_valid, 0);
        checkOutput("reset err_illegal", err_illegal, 0);
        checkOutput("reset err_div0", err_div0, 0);
        checkDbg(3'd1, 32'h0, "reset r1");

        // Directed vectors: instruction, register to inspect, its value, ready latency.
        vecs.push_back('{mk(OP_ADD, 1, 0, 0, 1, 16'h0025), 3'd1, 32'h00000025, 4});
        vecs.push_back('{mk(OP_ADD, 2, 0, 0, 1, 16'h0012), 3'd2, 32'h00000012, 4});
        vecs.push_back('{mk(OP_ADD, 3, 1, 2, 0, 16'h0000), 3'd3, 32'h00000037, 4});
        vecs.push_back('{mk(OP_SUB, 4, 1, 2, 0, 16'h0000), 3'd4, 32'h00000013, 4});
        vecs.push_back('{mk(OP_XOR, 4, 1, 2, 0, 16'h0000), 3'd4, 32'h00000037, 4});
        vecs.push_back('{mk(OP_ADD, 5, 0, 0, 1, 16'hFFFE), 3'd5, 32'hFFFFFFFE, 4});
        vecs.push_back('{mk(OP_ADD, 6, 0, 0, 1, 16'h0003), 3'd6, 32'h00000003, 4});
        vecs.push_back('{mk(OP_MUL, 6, 5, 6, 0, 16'h0000), 3'd6, 32'hFFFFFFFA, 5});
        vecs.push_back('{mk(OP_NOP, 0, 0, 0, 0, 16'h0000), 3'd7, 32'hFFFFFFFF, 1});
        vecs.push_back('{mk(OP_MUL, 7, 5, 3, 0, 16'h0000), 3'd7, 32'hFFFFFF92, 5});
        vecs.push_back('{mk(OP_NOP, 0, 0, 0, 0, 16'h0000), 3'd0, 32'h00000000, 1});
        vecs.push_back('{mk(OP_DIV, 3, 1, 0, 0, 16'h0000), 3'd3, 32'hFFFFFFFF, 2});
        vecs.push_back('{mk(5'h0A,  2, 1, 2, 0, 16'h0000), 3'd2, 32'h00000012, 1});
        vecs.push_back('{mk(OP_ADD, 1, 0, 0, 1, 16'h0001), 3'd1, 32'h00000001, 4});
        vecs.push_back('{mk(OP_ROL, 2, 1, 0, 1, 16'h001F), 3'd2, 32'h80000000, 4});
        vecs.push_back('{mk(OP_OR,  1, 1, 2, 0, 16'h0000), 3'd1, 32'h80000001, 4});
        vecs.push_back('{mk(OP_ROL, 1, 1, 0, 1, 16'h0001), 3'd1, 32'h00000003, 4});
        vecs.push_back('{mk(OP_ADD, 0, 0, 0, 1, 16'h0055), 3'd0, 32'h00000000, 4});
        vecs.push_back('{mk(OP_AND, 3, 6, 2, 0, 16'h0000), 3'd3, 32'h80000000, 4});
        vecs.push_back('{mk(OP_SHL, 4, 1, 0, 1, 16'h0004), 3'd4, 32'h00000030, 4});

        foreach (vecs[i]) begin
            string tag;
            int    lat0;
            tag = $sformatf("vec%0d", i);
            lat0 = total;
            runInstr(vecs[i].instr, tag);
            checkDbg(vecs[i].dbgAddr, vecs[i].expDbg, tag);
            if (lat0 == total) checkOutput({tag, " noChecks"}, 0, 1);
        end
        checkDbg(3'd6, 32'hFFFFFFFA, "mul lo kept");

        // Reset while an ADD sits in WAIT: nothing may be written back.
        applyStimulus(mk(OP_ADD, 1, 0, 0, 1, 16'h0077));
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midReset alu_op", alu_op, 0);
        checkOutput("midReset in_ready", in_ready, 1);
        wbSeen = 0;
        for (int k = 0; k < 4; k++) begin
            if (wb_valid) wbSeen++;
            @(negedge clk);
        end
        checkOutput("midReset noWb", wbSeen, 0);
        foreach (mdl[i]) mdl[i] = '0;
        for (int r = 0; r < 8; r++) checkDbg(3'(r), 32'h0, $sformatf("midReset r%0d", r));

        // Randomized stream against the model.
        for (int n = 0; n < 80; n++) begin
            rOp    = 5'($urandom_range(0, 11));
            rInstr = $urandom;
            rInstr[31:27] = rOp;
            if ($urandom_range(0, 3) == 0) rInstr[15:0] = 16'($urandom_range(0, 8));
            if (rOp == OP_DIV && $urandom_range(0, 1) == 0) begin
                rInstr[17]   = 1'b1;
                rInstr[15:0] = 16'h0000;
            end
            runInstr(rInstr, $sformatf("rand%0d", n));
        end
        for (int r = 0; r < 8; r++) checkDbg(3'(r), mdl[r], $sformatf("final r%0d", r));

        checkOutput("noDivZeroIssued", divZeroIssued, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit in case the stage wedges somewhere unexpected.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, wanted completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/alu_issue_wb.md
Name: alu_issue_wb

Overview:
Issue and writeback stage that sits directly in front of and behind the registered 5-bit-opcode ALU.
- Accepts one instruction at a time over a valid/ready handshake.
- Reads operands from an internal register file and drives registered alu_a/alu_b/alu_op.
- Waits for the ALU's clocked result and writes alu_out, or both halves of alu_out2 for MUL, back into the register file.
- Screens illegal opcodes and divide-by-zero so the ALU never sees them.

Parameters:
NREGS, 8, register-file depth; power of two; index width RW = log2(NREGS) = 3.
DW, 32, data width; must match the ALU operand width.

Ports:
clk  in  1  single clock; all state updates on its rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  instruction present.
in_instr  in  32  instruction word: [31:27] op, [26:24] rd, [23:21] rs1, [20:18] rs2, [17] imm_en, [16] reserved (ignored), [15:0] imm.
in_ready  out  1  stage can accept an instruction.
alu_a  out  32  registered operand A to the ALU.
alu_b  out  32  registered operand B to the ALU.
alu_op  out  5  registered opcode to the ALU.
alu_out  in  32  ALU 32-bit result.
alu_out2  in  64  ALU 64-bit MUL result.
wb_valid  out  1  one-cycle pulse per register-file write.
wb_addr  out  3  register written.
wb_data  out  32  value written.
err_illegal  out  1  one-cycle pulse: op > 5'h09.
err_div0  out  1  one-cycle pulse: DIV with operand B == 0.
dbg_addr  in  3  debug read address.
dbg_data  out  32  combinational read of the register file; r0 always reads 0.

Behaviour:
- Reset (rst=1 at a rising edge):
  - state <= IDLE; all registers <= 0.
  - alu_a, alu_b, alu_op <= 0 (NOP).
  - wb_valid, err_illegal, err_div0 <= 0.
  - in_ready is 1 in the cycle after reset.
  - Reset mid-instruction abandons it with no writeback.
- States: IDLE, EXEC, WAIT, WB, WB_HI.
  - in_ready = (state == IDLE).
  - A transfer occurs when in_valid & in_ready at a rising edge.
- IDLE, on transfer:
  - Decode the instruction.
  - Operand A = R[rs1].
  - Operand B = imm_en ? sign-extended imm : R[rs2].
  - Illegal op: pulse err_illegal next cycle, stay IDLE, alu_* unchanged.
  - op == DIV and B == 0: pulse err_div0, write 32'hFFFFFFFF to rd via the WB path (state -> WB with forced data), never drive DIV to the ALU.
  - op == NOP: accepted, no ALU issue, no writeback, stay IDLE.
  - Otherwise: load alu_a/alu_b/alu_op, latch rd and op, go to EXEC.
- EXEC: operands are stable on alu_* for this full cycle; the ALU captures at the end of the cycle. Go to WAIT.
- WAIT:
  - Restore alu_op <= NOP at the end of WAIT; alu_a/alu_b hold.
  - Go to WB.
  - The ALU result is valid during WB.
- WB:
  - Write R[rd] <= (op == MUL) ? alu_out2[31:0] : alu_out.
  - Pulse wb_valid with wb_addr/wb_data showing the write.
  - MUL -> WB_HI; else -> IDLE.
- WB_HI: write R[(rd+1) mod NREGS] <= alu_out2[63:32]; pulse wb_valid; -> IDLE.
- Throughput: 4 cycles per non-MUL instruction, 5 per MUL, from transfer to in_ready reasserting.
- r0 is hardwired zero:
  - Writes to r0 are suppressed, but wb_valid still pulses with wb_data = the discarded value.
  - A MUL with rd = 7 writes its high half to r0, which is likewise discarded.
- Arithmetic: operands are treated as signed; immediates are sign-extended to 32 bits; writeback is truncated to 32 bits except the MUL high half.
- Read-after-write hazards cannot occur: the next instruction is not accepted until writeback completes.
- wb_* values are held between pulses.
- in_instr changing while in_ready = 0 is ignored.

Decomposition:
- Shared package alu_pkg holds:
  - Opcode constants OP_NOP..OP_ROL = 5'h00..5'h09 and OP_MAX = 5'h09.
  - Instruction field positions.
  - The state enum.
  - Constant DIV0_RESULT = 32'hFFFFFFFF.
  - The ALU uses the same opcode constants.
- One sub-module, alu_regfile: NREGS x DW, two combinational read ports plus the debug port, one synchronous write port, r0 zero.
- Decode and FSM stay in alu_issue_wb.

Test Plan:
- Load via immediate ADD: ADD r1 = r0 + imm 0x0025, then ADD r2 = r0 + imm 0x0012 -> wb pulses (1, 0x25) and (2, 0x12); dbg r1 = 0x25.
- Register ADD and SUB: ADD r3 = r1 + r2 -> r3 = 0x37, with wb_valid exactly 3 cycles after transfer. SUB r4 = r1 - r2 -> 0x13.
- MUL with signed high half: r5 = imm 0xFFFE (-2), r6 = imm 0x0003, MUL rd = 6 -> r6 = 0xFFFFFFFA, r7 = 0xFFFFFFFF, two consecutive wb_valid pulses. MUL rd = 7 -> high half discarded, r0 stays 0.
- Error screening: DIV r3 = r1 / r0 -> err_div0 pulse, r3 = 0xFFFFFFFF, alu_op never 0x08. Opcode 0x0A -> err_illegal pulse, no wb_valid, in_ready stays 1.
- ROL, logic and r0 writes: ROL r1 with r1 = 0x80000001 -> 0x00000003. XOR 0x25 ^ 0x12 = 0x37. A write to r0 leaves dbg r0 = 0.
- Reset mid-operation: assert rst while in WAIT -> next cycle alu_op = 0, in_ready = 1, no wb_valid, all registers read 0. Holding in_valid high back-to-back is accepted only when in_ready = 1.
